// File: rtl/cache_ahb_pkg.sv
// rtl/cache_ahb_pkg.sv - shared AHB-Lite types and helpers for the cache bus fabric
// Purpose : transfer-type and data-phase-owner enums, response codes and an
//           address-region match helper used by the cache AHB decoder.
// Ports   : none (package).
package cache_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Owner of the data phase currently on the bus.
  typedef enum logic [1:0] {
    NONE = 2'b00,
    S0   = 2'b01,
    S1   = 2'b10,
    DEF  = 2'b11
  } dsel_t;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/cache_ahb_default_slave.sv
// rtl/cache_ahb_default_slave.sv - built-in default slave returning a two-cycle ERROR
// Purpose : answers unmapped active transfers with ERROR (hready low, then high).
// Ports   : i_hclk, i_hreset (sync, active-high)
//           i_sel    - an unmapped active transfer is in its address phase
//           i_ready  - bus HREADY (address phase accepted when high)
//           o_hready - default-slave HREADYOUT
//           o_hresp  - default-slave HRESP
module cache_ahb_default_slave
  import cache_ahb_pkg::*;
(
  input  logic i_hclk,
  input  logic i_hreset,
  input  logic i_sel,
  input  logic i_ready,
  output logic o_hready,
  output logic o_hresp
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } err_state_t;

  err_state_t state_q;
  err_state_t state_d;

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_ready && i_sel) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      // ERR2 completes the response; a new unmapped transfer accepted on
      // this same edge starts its own ERROR immediately.
      ST_ERR2: state_d = (i_ready && i_sel) ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_hready = 1'b1;
    o_hresp  = HRESP_OKAY;
    case (state_q)
      ST_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = HRESP_ERROR;
      end
      ST_ERR2: begin
        o_hready = 1'b1;
        o_hresp  = HRESP_ERROR;
      end
      default: begin
        o_hready = 1'b1;
        o_hresp  = HRESP_OKAY;
      end
    endcase
  end

endmodule

// File: rtl/cache_demux_ahb.sv
// rtl/cache_demux_ahb.sv - AHB-Lite decoder and response mux, one master to two slaves
// Purpose : decodes the master address phase to S0 (cache/memory) or S1
//           (bypass/peripheral), tracks the data-phase owner and muxes the
//           owning slave's response back; unmapped active transfers get ERROR.
// Ports   : i_hclk, i_hreset (sync, active-high)
//           i_h*            - master address/control/write data, i_hready_i bus HREADY
//           o_hready_o/o_hresp/o_hrdata - selected response to master
//           o_hsel0/o_hsel1 - per-slave selects
//           o_h*            - broadcast address/control/write data to both slaves
//           i_hready{0,1}_o/i_hresp{0,1}/i_hrdata{0,1} - slave responses
module cache_demux_ahb
  import cache_ahb_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hF000_0000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000
) (
  input  logic        i_hclk,
  input  logic        i_hreset,
  input  logic        i_hsel,
  input  logic [31:0] i_haddr,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [2:0]  i_hburst,
  input  logic [3:0]  i_hprot,
  input  logic [1:0]  i_htrans,
  input  logic        i_hmastlock,
  input  logic [31:0] i_hwdata,
  input  logic        i_hready_i,
  output logic        o_hready_o,
  output logic        o_hresp,
  output logic [31:0] o_hrdata,
  output logic        o_hsel0,
  output logic        o_hsel1,
  output logic [31:0] o_haddr,
  output logic        o_hwrite,
  output logic [2:0]  o_hsize,
  output logic [2:0]  o_hburst,
  output logic [3:0]  o_hprot,
  output logic [1:0]  o_htrans,
  output logic        o_hmastlock,
  output logic [31:0] o_hwdata,
  output logic        o_hready_i,
  input  logic        i_hready0_o,
  input  logic        i_hresp0,
  input  logic [31:0] i_hrdata0,
  input  logic        i_hready1_o,
  input  logic        i_hresp1,
  input  logic [31:0] i_hrdata1
);

  logic  hit0;
  logic  hit1;
  logic  miss;
  logic  def_sel;
  logic  def_hready;
  logic  def_hresp;
  dsel_t dsel;

  // S0 takes priority where the two regions overlap.
  assign hit0 = addr_hit(i_haddr, S0_BASE, S0_MASK);
  assign hit1 = addr_hit(i_haddr, S1_BASE, S1_MASK) & ~hit0;
  assign miss = ~hit0 & ~hit1;

  assign o_hsel0 = i_hsel & hit0;
  assign o_hsel1 = i_hsel & hit1;

  // htrans[1] set means NONSEQ or SEQ; IDLE/BUSY to a hole are answered OKAY.
  assign def_sel = i_hsel & miss & i_htrans[1];

  assign o_haddr     = i_haddr;
  assign o_hwrite    = i_hwrite;
  assign o_hsize     = i_hsize;
  assign o_hburst    = i_hburst;
  assign o_hprot     = i_hprot;
  assign o_htrans    = i_htrans;
  assign o_hmastlock = i_hmastlock;
  assign o_hwdata    = i_hwdata;
  assign o_hready_i  = i_hready_i;

  // The owner only moves when the current data phase completes, so an
  // address phase to another slave can pipeline under a stalled one.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      dsel <= NONE;
    end else if (i_hready_i) begin
      if (o_hsel0) begin
        dsel <= S0;
      end else if (o_hsel1) begin
        dsel <= S1;
      end else if (def_sel) begin
        dsel <= DEF;
      end else begin
        dsel <= NONE;
      end
    end
  end

  cache_ahb_default_slave u_default_slave (
    .i_hclk   (i_hclk),
    .i_hreset (i_hreset),
    .i_sel    (def_sel),
    .i_ready  (i_hready_i),
    .o_hready (def_hready),
    .o_hresp  (def_hresp)
  );

  always_comb begin
    o_hready_o = 1'b1;
    o_hresp    = HRESP_OKAY;
    o_hrdata   = 32'h0;
    case (dsel)
      S0: begin
        o_hready_o = i_hready0_o;
        o_hresp    = i_hresp0;
        o_hrdata   = i_hrdata0;
      end
      S1: begin
        o_hready_o = i_hready1_o;
        o_hresp    = i_hresp1;
        o_hrdata   = i_hrdata1;
      end
      DEF: begin
        o_hready_o = def_hready;
        o_hresp    = def_hresp;
        o_hrdata   = 32'h0;
      end
      default: begin
        o_hready_o = 1'b1;
        o_hresp    = HRESP_OKAY;
        o_hrdata   = 32'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_demux_ahb.sv
// tb/tb_cache_demux_ahb.sv - self-checking bench for cache_demux_ahb
module tb_cache_demux_ahb;

  logic        clk;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic        hsel0;
  logic        hsel1;
  logic [31:0] b_haddr;
  logic        b_hwrite;
  logic [2:0]  b_hsize;
  logic [2:0]  b_hburst;
  logic [3:0]  b_hprot;
  logic [1:0]  b_htrans;
  logic        b_hmastlock;
  logic [31:0] b_hwdata;
  logic        b_hready_i;
  logic        hready0;
  logic        hresp0;
  logic [31:0] hrdata0;
  logic        hready1;
  logic        hresp1;
  logic [31:0] hrdata1;

  logic        ov_hready;
  logic        ov_hresp;
  logic [31:0] ov_hrdata;
  logic        ov_hsel0;
  logic        ov_hsel1;
  logic [31:0] ov_haddr;
  logic        ov_hwrite;
  logic [2:0]  ov_hsize;
  logic [2:0]  ov_hburst;
  logic [3:0]  ov_hprot;
  logic [1:0]  ov_htrans;
  logic        ov_hmastlock;
  logic [31:0] ov_hwdata;
  logic        ov_hready_i;

  int checks = 0;
  int errors = 0;

  cache_demux_ahb dut (
    .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel), .i_haddr(haddr),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot),
    .i_htrans(htrans), .i_hmastlock(hmastlock), .i_hwdata(hwdata),
    .i_hready_i(hready), .o_hready_o(hready), .o_hresp(hresp), .o_hrdata(hrdata),
    .o_hsel0(hsel0), .o_hsel1(hsel1), .o_haddr(b_haddr), .o_hwrite(b_hwrite),
    .o_hsize(b_hsize), .o_hburst(b_hburst), .o_hprot(b_hprot), .o_htrans(b_htrans),
    .o_hmastlock(b_hmastlock), .o_hwdata(b_hwdata), .o_hready_i(b_hready_i),
    .i_hready0_o(hready0), .i_hresp0(hresp0), .i_hrdata0(hrdata0),
    .i_hready1_o(hready1), .i_hresp1(hresp1), .i_hrdata1(hrdata1)
  );

  cache_demux_ahb #(.S1_BASE(32'h0000_0000)) dut_ov (
    .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel), .i_haddr(haddr),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot),
    .i_htrans(htrans), .i_hmastlock(hmastlock), .i_hwdata(hwdata),
    .i_hready_i(ov_hready), .o_hready_o(ov_hready), .o_hresp(ov_hresp), .o_hrdata(ov_hrdata),
    .o_hsel0(ov_hsel0), .o_hsel1(ov_hsel1), .o_haddr(ov_haddr), .o_hwrite(ov_hwrite),
    .o_hsize(ov_hsize), .o_hburst(ov_hburst), .o_hprot(ov_hprot), .o_htrans(ov_htrans),
    .o_hmastlock(ov_hmastlock), .o_hwdata(ov_hwdata), .o_hready_i(ov_hready_i),
    .i_hready0_o(hready0), .i_hresp0(hresp0), .i_hrdata0(hrdata0),
    .i_hready1_o(hready1), .i_hresp1(hresp1), .i_hrdata1(hrdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic sel, input logic [31:0] a,
                            input logic [1:0] tr, input logic wr);
    hsel   = sel;
    haddr  = a;
    htrans = tr;
    hwrite = wr;
  endtask

  // Reference model: owner 0=none 1=S0 2=S1 3=default; err_half marks the
  // second (ready-high) cycle of a default-slave ERROR.
  int m_owner;
  int m_half;

  function automatic int region(input logic [31:0] a);
    if ((a >> 28) == 0) return 1;
    if ((a >> 28) == 2) return 2;
    return 0;
  endfunction

  initial begin
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    int          r;

    hreset = 1'b1; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; hprot = 4'h3; htrans = 2'b00; hmastlock = 1'b0; hwdata = '0;
    hready0 = 1'b1; hresp0 = 1'b0; hrdata0 = '0;
    hready1 = 1'b1; hresp1 = 1'b0; hrdata1 = '0;
    next_cycle();
    next_cycle();

    // Reset state, with the first address phase already presented.
    addr_phase(1'b1, 32'h0000_0010, 2'b10, 1'b0);
    @(negedge clk);
    check("rst_hready", hready, 1);
    check("rst_hresp", hresp, 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_hsel0", hsel0, 1);
    next_cycle();
    hreset = 1'b0;
    @(negedge clk);
    check("s0_addr_hsel0", hsel0, 1);
    check("s0_addr_hsel1", hsel1, 0);
    next_cycle();
    addr_phase(1'b0, 32'h0, 2'b00, 1'b0);
    hrdata0 = 32'hCAFE_0001;
    @(negedge clk);
    check("s0_data_hrdata", hrdata, 32'hCAFE_0001);
    check("s0_data_hready", hready, 1);

    // S0 read with two wait states, S1 read pipelined behind it.
    next_cycle();
    addr_phase(1'b1, 32'h0000_0000, 2'b10, 1'b0);
    next_cycle();
    addr_phase(1'b1, 32'h2000_0004, 2'b10, 1'b0);
    hready0 = 1'b0; hrdata0 = 32'hDEAD_0000; hrdata1 = 32'hBEEF_1111;
    @(negedge clk);
    check("b2b_wait1_hready", hready, 0);
    check("b2b_addr_hsel1", hsel1, 1);
    next_cycle();
    @(negedge clk);
    check("b2b_wait2_hready", hready, 0);
    next_cycle();
    hready0 = 1'b1; hrdata0 = 32'h5A5A_0000;
    @(negedge clk);
    check("b2b_s0_hrdata", hrdata, 32'h5A5A_0000);
    check("b2b_s0_hready", hready, 1);
    next_cycle();
    addr_phase(1'b0, 32'h0, 2'b00, 1'b0);
    hrdata0 = 32'hDEAD_0000;
    @(negedge clk);
    check("b2b_s1_hrdata", hrdata, 32'hBEEF_1111);
    check("b2b_s1_hready", hready, 1);

    // Unmapped NONSEQ write: two-cycle ERROR then OKAY.
    next_cycle();
    addr_phase(1'b1, 32'h5000_0000, 2'b10, 1'b1);
    @(negedge clk);
    check("unm_hsel0", hsel0, 0);
    check("unm_hsel1", hsel1, 0);
    next_cycle();
    addr_phase(1'b0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    check("err1_hready", hready, 0);
    check("err1_hresp", hresp, 1);
    check("err1_hrdata", hrdata, 0);
    next_cycle();
    @(negedge clk);
    check("err2_hready", hready, 1);
    check("err2_hresp", hresp, 1);
    next_cycle();
    @(negedge clk);
    check("post_err_hready", hready, 1);
    check("post_err_hresp", hresp, 0);

    // IDLE transfer to a hole is a zero-wait OKAY.
    addr_phase(1'b1, 32'h5000_0000, 2'b00, 1'b0);
    next_cycle();
    addr_phase(1'b0, 32'h0, 2'b00, 1'b0);
    @(negedge clk);
    check("idle_unm_hready", hready, 1);
    check("idle_unm_hresp", hresp, 0);

    // Overlapping regions: S0 wins.
    addr_phase(1'b1, 32'h0000_0100, 2'b10, 1'b0);
    @(negedge clk);
    check("ov_hsel0", ov_hsel0, 1);
    check("ov_hsel1", ov_hsel1, 0);
    next_cycle();

    // Reset during an S1 wait state discards the response.
    addr_phase(1'b1, 32'h2000_0000, 2'b10, 1'b0);
    next_cycle();
    addr_phase(1'b0, 32'h0, 2'b00, 1'b0);
    hready1 = 1'b0; hresp1 = 1'b1; hrdata1 = 32'hFFFF_FFFF;
    @(negedge clk);
    check("s1_wait_hready", hready, 0);
    hreset = 1'b1;
    next_cycle();
    hreset = 1'b0;
    @(negedge clk);
    check("rst_mid_hready", hready, 1);
    check("rst_mid_hresp", hresp, 0);
    check("rst_mid_hrdata", hrdata, 0);

    // Randomized traffic against the reference model.
    m_owner = 0;
    m_half  = 0;
    next_cycle();
    for (int n = 0; n < 800; n++) begin
      hsel = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 4);
      case (r)
        0: haddr = 32'h0000_0000 | ($urandom & 32'h0FFF_FFFC);
        1: haddr = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
        2: haddr = 32'h5000_0000 | ($urandom & 32'h0FFF_FFFC);
        3: haddr = 32'hF000_0000 | ($urandom & 32'h0FFF_FFFC);
        default: haddr = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
      endcase
      htrans  = 2'($urandom_range(0, 3));
      hwrite  = 1'($urandom_range(0, 1));
      hwdata  = $urandom;
      hready0 = ($urandom_range(0, 3) != 0);
      hresp0  = ($urandom_range(0, 7) == 0);
      hrdata0 = $urandom;
      hready1 = ($urandom_range(0, 3) != 0);
      hresp1  = ($urandom_range(0, 7) == 0);
      hrdata1 = $urandom;
      hreset  = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      case (m_owner)
        1: begin e_rdy = hready0; e_resp = hresp0; e_data = hrdata0; end
        2: begin e_rdy = hready1; e_resp = hresp1; e_data = hrdata1; end
        3: begin e_rdy = (m_half == 1); e_resp = 1'b1; e_data = 32'h0; end
        default: begin e_rdy = 1'b1; e_resp = 1'b0; e_data = 32'h0; end
      endcase
      check("rnd_hready", hready, e_rdy);
      check("rnd_hresp", hresp, e_resp);
      check("rnd_hrdata", hrdata, e_data);
      check("rnd_hsel0", hsel0, hsel && region(haddr) == 1);
      check("rnd_hsel1", hsel1, hsel && region(haddr) == 2);
      check("rnd_bcast_haddr", b_haddr, haddr);
      check("rnd_bcast_hwdata", b_hwdata, hwdata);
      if (hreset) begin
        m_owner = 0;
        m_half  = 0;
      end else if (e_rdy) begin
        m_half = 0;
        if (!hsel) m_owner = 0;
        else if (region(haddr) != 0) m_owner = region(haddr);
        else if (htrans >= 2) m_owner = 3;
        else m_owner = 0;
      end else if (m_owner == 3) begin
        m_half = 1;
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
